receiver: RTL and testbench
===========================

RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter SYNC_LOCK, default 3: number of consecutive good words needed to enter LOCKED (range 1-7).
REQ-002 Parameter SYNC_LOSS, default 4: number of consecutive bad words in LOCKED needed to return to HUNT (range 1-7).
REQ-003 i_clk  input  1  Single clock; all logic on the rising edge.
REQ-004 i_rst  input  1  Reset, synchronous, active-high.
REQ-005 enable  input  1  Sample qualifier; i_data is consumed only on edges where enable=1.
REQ-006 i_data  input  20  Word from the upstream transmitter.
REQ-007 o_payload  output  8  Payload of the last accepted word.
REQ-008 o_valid  output  1  One-cycle strobe; o_payload is new this cycle.
REQ-009 o_locked  output  1  High while the FSM is in LOCKED.
REQ-010 o_seq_err  output  1  One-cycle strobe on a sequence mismatch while LOCKED.
REQ-011 o_err_cnt  output  16  Saturating count of bad words received while LOCKED.

Function
REQ-012 The word format SHALL be: [19:17] sync = 3'b101, [16] even-parity bit over [15:0], [15:8] sequence number, [7:0] payload.
REQ-013 A sampled word SHALL be "framed" when its sync field matches and, if parity checking is compiled in, its parity is correct.
REQ-014 A sampled word SHALL be "good" when it is framed and, in CHECK or LOCKED, its sequence number equals the expected sequence number.
REQ-015 The FSM SHALL have the states HUNT, CHECK and LOCKED.
REQ-016 HUNT: on a framed word -> expected = seq+1, good_cnt = 1, next state CHECK (or LOCKED directly if SYNC_LOCK=1); on any other word -> stay in HUNT.
REQ-017 CHECK: on a good word -> good_cnt++ and expected++; when good_cnt reaches SYNC_LOCK -> LOCKED. On a bad word -> HUNT, good_cnt cleared.
REQ-018 LOCKED, good word: o_valid=1, o_payload=payload, bad_cnt cleared, expected++.
REQ-019 LOCKED, bad word: bad_cnt++, o_err_cnt++ (saturating at 16'hFFFF), no o_valid; when bad_cnt reaches SYNC_LOSS -> HUNT.
REQ-020 LOCKED, framed word with wrong sequence number: o_seq_err=1 and expected is realigned to received seq+1.
REQ-021 The word that completes lock (CHECK->LOCKED transition) SHALL also be output with o_valid=1.
REQ-022 Expected-sequence arithmetic SHALL be modulo 256; 8'hFF is followed by 8'h00, and this wrap is not an error.
REQ-023 Outputs SHALL be registered; o_valid, o_seq_err and o_err_cnt update one i_clk after the sampling edge (latency 1).
REQ-024 When enable=0: no word is sampled, FSM state and all counters hold, and o_valid=o_seq_err=0; o_payload holds its last value.
REQ-025 o_locked SHALL equal the registered state==LOCKED, so it goes high in the same cycle as the first o_valid.

Reset
REQ-026 While i_rst=1 at a rising edge, all registers SHALL be cleared on that edge: state=HUNT, expected=0, good_cnt=bad_cnt=0, o_payload=0, o_valid=0, o_locked=0, o_seq_err=0, o_err_cnt=0.
REQ-027 Reset SHALL take priority over enable, including when asserted mid-lock; operation resumes in HUNT on the first edge after i_rst falls.

Configuration
REQ-028 Parity checking is controlled by the macro RX_PARITY_CHECK_EN.
REQ-029 With RX_PARITY_CHECK_EN defined: a word with a parity error is not framed (and therefore bad).
REQ-030 Without RX_PARITY_CHECK_EN: bit 16 is ignored and no parity logic is instantiated.

Verification
REQ-031 Stimulus: reset, then enable=1 with good words seq 0x00..0x05, payload 0x10..0x15 (default parameters). Required response: o_locked rises when seq 0x02 is accepted; o_valid pulses carrying 0x12..0x15.
REQ-032 Stimulus: while LOCKED, send seq 0xFE, 0xFF, 0x00, 0x01. Required response: four o_valid pulses, no o_seq_err, o_err_cnt unchanged.
REQ-033 Stimulus: while LOCKED, send seq 0x20 then 0x22. Required response: one o_seq_err pulse, o_err_cnt +1, expected becomes 0x23, and the next word 0x23 is accepted.
REQ-034 Stimulus: while LOCKED, send 4 words with sync=3'b000. Required response: o_locked falls after the 4th word, o_err_cnt +4, no o_valid.
REQ-035 Stimulus: with RX_PARITY_CHECK_EN defined, send a locked-stream word with bit 16 flipped. Required response: word rejected and o_err_cnt +1. Without the macro, the same word is accepted with o_valid=1.
REQ-036 Stimulus: assert i_rst for one cycle mid-lock, with enable toggling. Required response: all outputs 0 on the next edge; relock follows REQ-031 timing; no sampling occurs in enable=0 cycles.

Source files
------------

// File: rtl/receiver.sv
// Framed-word receiver: hunts for 3'b101 sync, locks after SYNC_LOCK in-sequence words, drops after SYNC_LOSS bad ones.
// Optional even-parity check on bit 16 is compiled in with `define RX_PARITY_CHECK_EN.
module receiver #(
  parameter int SYNC_LOCK = 3,
  parameter int SYNC_LOSS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        enable,
  input  logic [19:0] i_data,
  output logic [7:0]  o_payload,
  output logic        o_valid,
  output logic        o_locked,
  output logic        o_seq_err,
  output logic [15:0] o_err_cnt
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [2:0] SYNC_WORD = 3'b101;
  localparam logic [2:0] LOCK_N    = 3'(SYNC_LOCK);
  localparam logic [2:0] LOSS_N    = 3'(SYNC_LOSS);

  state_e      state_q;
  logic [7:0]  expected_q;
  logic [2:0]  good_cnt_q;
  logic [2:0]  bad_cnt_q;
  logic [7:0]  payload_q;
  logic        valid_q;
  logic        seq_err_q;
  logic [15:0] err_cnt_q;

  logic [7:0]  rx_seq;
  logic [7:0]  rx_payload;
  logic [7:0]  rx_seq_next;
  logic [7:0]  expected_d;
  logic [2:0]  good_cnt_d;
  logic [2:0]  bad_cnt_d;
  logic        sync_ok;
  logic        parity_ok;
  logic        framed;
  logic        good;
  logic        err_cnt_sat;

  assign rx_seq      = i_data[15:8];
  assign rx_payload  = i_data[7:0];
  assign rx_seq_next = rx_seq + 8'd1;
  assign expected_d  = expected_q + 8'd1;
  assign good_cnt_d  = good_cnt_q + 3'd1;
  assign bad_cnt_d   = bad_cnt_q + 3'd1;
  assign sync_ok     = (i_data[19:17] == SYNC_WORD);
  assign err_cnt_sat = &err_cnt_q;

`ifdef RX_PARITY_CHECK_EN
  // Even parity: bit 16 makes the XOR of bits [16:0] zero.
  assign parity_ok = ~(^i_data[16:0]);
`else
  logic unused_parity_bit;
  assign unused_parity_bit = i_data[16];
  assign parity_ok         = 1'b1;
`endif

  assign framed = sync_ok & parity_ok;
  assign good   = framed & (rx_seq == expected_q);

  // NOTE: every register in this block uses <= so all next values derive from pre-edge state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= HUNT;
      expected_q <= '0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      payload_q  <= '0;
      valid_q    <= 1'b0;
      seq_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      valid_q   <= 1'b0;
      seq_err_q <= 1'b0;
      if (enable) begin
        unique case (state_q)
          HUNT: begin
            if (framed) begin
              expected_q <= rx_seq_next;
              good_cnt_q <= 3'd1;
              bad_cnt_q  <= '0;
              if (LOCK_N == 3'd1) begin
                state_q   <= LOCKED;
                valid_q   <= 1'b1;
                payload_q <= rx_payload;
              end else begin
                state_q <= CHECK;
              end
            end
          end
          CHECK: begin
            if (good) begin
              expected_q <= expected_d;
              good_cnt_q <= good_cnt_d;
              if (good_cnt_d == LOCK_N) begin
                state_q   <= LOCKED;
                valid_q   <= 1'b1;
                payload_q <= rx_payload;
              end
            end else begin
              state_q    <= HUNT;
              good_cnt_q <= '0;
            end
          end
          LOCKED: begin
            if (good) begin
              valid_q    <= 1'b1;
              payload_q  <= rx_payload;
              bad_cnt_q  <= '0;
              expected_q <= expected_d;
            end else begin
              bad_cnt_q <= bad_cnt_d;
              if (!err_cnt_sat) begin
                err_cnt_q <= err_cnt_q + 16'd1;
              end
              // A framed word with the wrong number realigns the expected sequence.
              if (framed) begin
                seq_err_q  <= 1'b1;
                expected_q <= rx_seq_next;
              end
              if (bad_cnt_d == LOSS_N) begin
                state_q    <= HUNT;
                bad_cnt_q  <= '0;
                good_cnt_q <= '0;
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign o_payload = payload_q;
  assign o_valid   = valid_q;
  assign o_locked  = (state_q == LOCKED);
  assign o_seq_err = seq_err_q;
  assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: directed scenarios plus random words against a behavioural model.
module tb_receiver;

  localparam int SYNC_LOCK = 3;
  localparam int SYNC_LOSS = 4;
  localparam int M_HUNT    = 0;
  localparam int M_CHECK   = 1;
  localparam int M_LOCKED  = 2;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        enable = 1'b0;
  logic [19:0] i_data = '0;
  logic [7:0]  o_payload;
  logic        o_valid;
  logic        o_locked;
  logic        o_seq_err;
  logic [15:0] o_err_cnt;

  receiver #(.SYNC_LOCK(SYNC_LOCK), .SYNC_LOSS(SYNC_LOSS)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .enable   (enable),
    .i_data   (i_data),
    .o_payload(o_payload),
    .o_valid  (o_valid),
    .o_locked (o_locked),
    .o_seq_err(o_seq_err),
    .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: mode, expected sequence, run lengths, outputs.
  int m_mode    = M_HUNT;
  int m_exp     = 0;
  int m_run     = 0;
  int m_bad     = 0;
  int m_err     = 0;
  int m_payload = 0;
  int m_valid   = 0;
  int m_seq_err = 0;

  function automatic logic [19:0] mk_word(input int seq, input int pay, input logic [2:0] sync,
                                          input logic flip);
    logic [7:0] s;
    logic [7:0] p;
    s = seq[7:0];
    p = pay[7:0];
    return {sync, (^{s, p}) ^ flip, s, p};
  endfunction

  function automatic int word_parity_ok(input logic [19:0] w);
`ifdef RX_PARITY_CHECK_EN
    return ((^w[16:0]) == 1'b0) ? 1 : 0;
`else
    return (w[16] === 1'b0 || w[16] === 1'b1) ? 1 : 0;
`endif
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic en, input logic [19:0] w);
    int seq;
    int framed;
    int good;
    m_valid   = 0;
    m_seq_err = 0;
    if (rst) begin
      m_mode = M_HUNT; m_exp = 0; m_run = 0; m_bad = 0; m_err = 0; m_payload = 0;
      return;
    end
    if (!en) return;
    seq    = int'(w[15:8]);
    framed = (w[19:17] == 3'b101 && word_parity_ok(w) == 1) ? 1 : 0;
    good   = (framed == 1 && seq == m_exp) ? 1 : 0;
    if (m_mode == M_HUNT) begin
      if (framed == 1) begin
        m_exp = (seq + 1) % 256;
        m_run = 1;
        if (m_run >= SYNC_LOCK) begin
          m_mode = M_LOCKED; m_valid = 1; m_payload = int'(w[7:0]);
        end else begin
          m_mode = M_CHECK;
        end
      end
    end else if (m_mode == M_CHECK) begin
      if (good == 1) begin
        m_run = m_run + 1;
        m_exp = (m_exp + 1) % 256;
        if (m_run == SYNC_LOCK) begin
          m_mode = M_LOCKED; m_valid = 1; m_payload = int'(w[7:0]); m_bad = 0;
        end
      end else begin
        m_mode = M_HUNT; m_run = 0;
      end
    end else begin
      if (good == 1) begin
        m_valid = 1; m_payload = int'(w[7:0]); m_bad = 0;
        m_exp = (m_exp + 1) % 256;
      end else begin
        m_bad = m_bad + 1;
        if (m_err < 65535) m_err = m_err + 1;
        if (framed == 1) begin
          m_seq_err = 1;
          m_exp = (seq + 1) % 256;
        end
        if (m_bad == SYNC_LOSS) begin
          m_mode = M_HUNT; m_bad = 0; m_run = 0;
        end
      end
    end
  endtask

  // Drive one cycle at the falling edge, let the rising edge sample it, compare at the next falling edge.
  task automatic step(input logic rst, input logic en, input logic [19:0] w);
    i_rst  = rst;
    enable = en;
    i_data = w;
    model_step(rst, en, w);
    @(posedge i_clk);
    @(negedge i_clk);
    check("valid",   {15'h0, o_valid},   16'(m_valid));
    check("payload", {8'h00, o_payload}, 16'(m_payload));
    check("locked",  {15'h0, o_locked},  (m_mode == M_LOCKED) ? 16'd1 : 16'd0);
    check("seq_err", {15'h0, o_seq_err}, 16'(m_seq_err));
    check("err_cnt", o_err_cnt,          16'(m_err));
  endtask

  task automatic good_word(input int pay);
    step(1'b0, 1'b1, mk_word(m_exp, pay, 3'b101, 1'b0));
  endtask

  initial begin
    int vcount;
    int scount;
    int err_before;
    logic [31:0] r32;
    logic [2:0] bad_sync;

    @(negedge i_clk);
    // Reset state.
    step(1'b1, 1'b0, 20'h0);
    step(1'b1, 1'b1, mk_word(0, 8'h10, 3'b101, 1'b0));
    check("rst_locked", {15'h0, o_locked}, 16'd0);

    // Acquire lock on seq 0x00..0x05, payload 0x10..0x15.
    for (int s = 0; s < 6; s++) begin
      step(1'b0, 1'b1, mk_word(s, 8'h10 + s, 3'b101, 1'b0));
      if (s == 1) check("pre_lock", {15'h0, o_locked}, 16'd0);
      if (s == 2) begin
        check("lock_at_seq2", {15'h0, o_locked}, 16'd1);
        check("lock_payload", {8'h00, o_payload}, 16'h0012);
      end
    end

    // Sequence wrap 0xFE,0xFF,0x00,0x01 after relocking at 0xFB..0xFD.
    step(1'b1, 1'b1, 20'h0);
    for (int s = 'hFB; s <= 'hFD; s++) step(1'b0, 1'b1, mk_word(s, 8'h30, 3'b101, 1'b0));
    err_before = int'(o_err_cnt);
    vcount = 0;
    scount = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, mk_word(('hFE + k) % 256, 8'h40 + k, 3'b101, 1'b0));
      vcount += int'(o_valid);
      scount += int'(o_seq_err);
    end
    check("wrap_valids", 16'(vcount), 16'd4);
    check("wrap_seq_errs", 16'(scount), 16'd0);
    check("wrap_err_cnt", o_err_cnt, 16'(err_before));

    // Sequence skip: 0x20 then 0x22, then 0x23 is accepted.
    for (int s = 2; s <= 'h20; s++) step(1'b0, 1'b1, mk_word(s, s, 3'b101, 1'b0));
    err_before = int'(o_err_cnt);
    step(1'b0, 1'b1, mk_word('h22, 8'h77, 3'b101, 1'b0));
    check("skip_seq_err", {15'h0, o_seq_err}, 16'd1);
    check("skip_err_inc", o_err_cnt, 16'(err_before + 1));
    step(1'b0, 1'b1, mk_word('h23, 8'h78, 3'b101, 1'b0));
    check("realign_valid", {15'h0, o_valid}, 16'd1);
    check("realign_payload", {8'h00, o_payload}, 16'h0078);

    // Four unframed words drop lock.
    err_before = int'(o_err_cnt);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, mk_word('h24 + k, 8'h55, 3'b000, 1'b0));
      if (k == 2) check("loss_hold", {15'h0, o_locked}, 16'd1);
    end
    check("loss_drop", {15'h0, o_locked}, 16'd0);
    check("loss_err_inc", o_err_cnt, 16'(err_before + 4));

    // Parity-flipped word while locked.
    for (int s = 'h40; s <= 'h42; s++) step(1'b0, 1'b1, mk_word(s, 8'h60, 3'b101, 1'b0));
    err_before = int'(o_err_cnt);
    step(1'b0, 1'b1, mk_word('h43, 8'h61, 3'b101, 1'b1));
`ifdef RX_PARITY_CHECK_EN
    check("parity_valid", {15'h0, o_valid}, 16'd0);
    check("parity_err_inc", o_err_cnt, 16'(err_before + 1));
`else
    check("parity_valid", {15'h0, o_valid}, 16'd1);
    check("parity_err_inc", o_err_cnt, 16'(err_before));
`endif
    good_word(8'h62);

    // One-cycle reset mid-lock, then relock with enable toggling and decoy words in idle cycles.
    step(1'b1, 1'b1, mk_word(m_exp, 8'h63, 3'b101, 1'b0));
    check("midrst_err", o_err_cnt, 16'd0);
    check("midrst_payload", {8'h00, o_payload}, 16'd0);
    for (int s = 0; s < 3; s++) begin
      step(1'b0, 1'b1, mk_word(s, 8'h10 + s, 3'b101, 1'b0));
      if (s < 2) step(1'b0, 1'b0, mk_word('h55, 8'hEE, 3'b101, 1'b0));
    end
    check("relock", {15'h0, o_locked}, 16'd1);
    check("relock_payload", {8'h00, o_payload}, 16'h0012);
    step(1'b0, 1'b0, mk_word('h99, 8'hAB, 3'b000, 1'b0));
    check("idle_hold_payload", {8'h00, o_payload}, 16'h0012);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic en;
      logic rst;
      int kind;
      logic [19:0] w;
      en   = ($urandom_range(0, 99) < 85);
      rst  = ($urandom_range(0, 199) == 0);
      kind = $urandom_range(0, 9);
      r32  = $urandom();
      case (kind)
        0, 1, 2, 3, 4, 5: w = mk_word(m_exp, int'(r32[7:0]), 3'b101, 1'b0);
        6: w = mk_word((m_exp + 1 + $urandom_range(0, 253)) % 256, int'(r32[7:0]), 3'b101, 1'b0);
        7: begin
          bad_sync = r32[10:8];
          if (bad_sync == 3'b101) bad_sync = 3'b111;
          w = mk_word(m_exp, int'(r32[7:0]), bad_sync, 1'b0);
        end
        8: w = mk_word(m_exp, int'(r32[7:0]), 3'b101, 1'b1);
        default: w = r32[19:0];
      endcase
      step(rst, en, w);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
